// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared state encoding and stage indices for the hazard controller
// Revision: 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Bit index into en/clear for each pipeline register
  localparam int PS1 = 0;  // IF/ID
  localparam int PS2 = 1;  // ID/EX
  localparam int PS3 = 2;  // EX/MEM
  localparam int PS4 = 3;  // MEM/WB

  localparam int MEM_LAT_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_event_counter.sv
`default_nettype none
// ============================================================================
// Module  : event_counter
// Brief   : Wrapping event counter with increment strobe
// Revision: 1.0  initial release
// ============================================================================
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush/freeze/halt controller for the 5-stage pipeline
// Revision: 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_r_datamem,
  input  logic             ex_regfile_w_en,
  input  logic [4:0]       ex_regfile_req_w,
  input  logic             ex_is_branch,
  input  logic             ex_mispredict,
  input  logic             mem_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic [3:0]       en,
  output logic [3:0]       clear,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam int             CW         = $clog2(MEM_LAT) + 1;
  localparam logic           c_MULTI    = (MEM_LAT > 1);
  localparam logic [CW-1:0]  c_CNT_LOAD = (MEM_LAT > 1) ? CW'(MEM_LAT - 2) : '0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wait_done;

  logic w_mem_start;
  logic w_freeze;
  logic w_mispredict;
  logic w_load_use;

  assign w_mem_start  = (r_state == ST_RUN) & mem_req & ~r_wait_done & c_MULTI;
  assign w_mispredict = ex_is_branch & ex_mispredict;
  assign w_load_use   = ex_r_datamem & ex_regfile_w_en & (ex_regfile_req_w != 5'd0) &
                        ((id_use_rs & (id_rs == ex_regfile_req_w)) |
                         (id_use_rt & (id_rt == ex_regfile_req_w)));

  always_comb begin
    w_freeze = 1'b1;
    case (r_state)
      ST_RUN:      w_freeze = w_mem_start;
      ST_MEM_WAIT: w_freeze = (r_cnt != '0);
      default:     w_freeze = 1'b1;
    endcase
  end

  always_comb begin
    pc_en = 1'b0;
    en    = 4'b0000;
    clear = 4'b0000;
    if (!w_freeze) begin
      if (w_mispredict) begin
        pc_en      = 1'b1;
        en         = 4'b1111;
        clear[PS1] = 1'b1;
        clear[PS2] = 1'b1;
      end else if (w_load_use) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX
        en         = 4'b1111;
        en[PS1]    = 1'b0;
        clear[PS2] = 1'b1;
      end else begin
        pc_en = 1'b1;
        en    = 4'b1111;
      end
    end
  end

  assign halted = (r_state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_wait_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_start) begin
            r_cnt   <= c_CNT_LOAD;
            r_state <= ST_MEM_WAIT;
          end else begin
            r_wait_done <= 1'b0;
            if (halt_req) r_state <= ST_HALT;
          end
        end
        ST_MEM_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Blocks the still-asserted mem_req from restarting the wait
            r_wait_done <= 1'b1;
            r_state     <= halt_req ? ST_HALT : ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  logic w_stall_inc;
  logic w_flush_inc;
  logic w_branch_inc;

  assign w_stall_inc  = ~pc_en & ~halted;
  assign w_flush_inc  = ~w_freeze & w_mispredict;
  assign w_branch_inc = ~w_freeze & ex_is_branch;

  event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_branch_inc),
    .o_count (branch_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl
// Revision: 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_regfile_req_w;
  logic             id_use_rs, id_use_rt, ex_r_datamem, ex_regfile_w_en;
  logic             ex_is_branch, ex_mispredict, mem_req, halt_req, resume;
  logic             pc_en, halted;
  logic [3:0]       en, clear;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, branch_cnt;
  logic             pc_en1, halted1;
  logic [3:0]       en1, clear1;
  logic [CNT_W-1:0] stall_cnt1, flush_cnt1, branch_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_r_datamem(ex_r_datamem),
    .ex_regfile_w_en(ex_regfile_w_en), .ex_regfile_req_w(ex_regfile_req_w),
    .ex_is_branch(ex_is_branch), .ex_mispredict(ex_mispredict), .mem_req(mem_req),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .en(en), .clear(clear),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .branch_cnt(branch_cnt)
  );

  // Single-cycle memory variant: mem_req must never freeze
  pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_r_datamem(ex_r_datamem),
    .ex_regfile_w_en(ex_regfile_w_en), .ex_regfile_req_w(ex_regfile_req_w),
    .ex_is_branch(ex_is_branch), .ex_mispredict(ex_mispredict), .mem_req(mem_req),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en1), .en(en1), .clear(clear1),
    .halted(halted1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .branch_cnt(branch_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_r_datamem = 0; ex_regfile_w_en = 0; ex_regfile_req_w = 0;
    ex_is_branch = 0; ex_mispredict = 0; mem_req = 0; halt_req = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    ex_r_datamem = 1; ex_regfile_w_en = 1; ex_regfile_req_w = r;
    id_use_rs = 1; id_rs = r;
  endtask

  task automatic outs(input string tag, input logic p, input logic [3:0] e,
                      input logic [3:0] c, input logic h);
    #1;
    check({tag, ".pc_en"}, 32'(pc_en), 32'(p));
    check({tag, ".en"}, 32'(en), 32'(e));
    check({tag, ".clear"}, 32'(clear), 32'(c));
    check({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic cnts(input string tag, input int s, input int f, input int b);
    check({tag, ".stall"}, 32'(stall_cnt), 32'(s));
    check({tag, ".flush"}, 32'(flush_cnt), 32'(f));
    check({tag, ".branch"}, 32'(branch_cnt), 32'(b));
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    outs("rst", 1, 4'hF, 4'h0, 0);
    cnts("rst", 0, 0, 0);
    rst_n = 1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      outs("idle", 1, 4'hF, 4'h0, 0);
      tick();
    end
    cnts("idle", 0, 0, 0);

    // 2: load-use on rs, then x0 destination, then rt path, then rt unused
    load_use_rs(5'd5);
    outs("lu_rs", 0, 4'hE, 4'h2, 0);
    tick(); cnts("lu_rs", 1, 0, 0);
    load_use_rs(5'd0);
    outs("lu_x0", 1, 4'hF, 4'h0, 0);
    tick(); cnts("lu_x0", 1, 0, 0);
    idle();
    ex_r_datamem = 1; ex_regfile_w_en = 1; ex_regfile_req_w = 7; id_use_rt = 1; id_rt = 7;
    outs("lu_rt", 0, 4'hE, 4'h2, 0);
    tick(); cnts("lu_rt", 2, 0, 0);
    id_use_rt = 0;
    outs("lu_rt_unused", 1, 4'hF, 4'h0, 0);
    tick(); idle();

    // 3: mispredict overrides load-use; correct branch only counts
    load_use_rs(5'd5); ex_is_branch = 1; ex_mispredict = 1;
    outs("mispred", 1, 4'hF, 4'h3, 0);
    tick(); cnts("mispred", 2, 1, 1);
    idle(); ex_is_branch = 1;
    outs("br_ok", 1, 4'hF, 4'h0, 0);
    tick(); cnts("br_ok", 2, 1, 2);
    idle();

    // resume outside HALT has no effect
    resume = 1;
    tick(); resume = 0;
    outs("resume_run", 1, 4'hF, 4'h0, 0);

    // 4: MEM_LAT=3 with mem_req held four cycles
    mem_req = 1;
    outs("mem_a", 0, 4'h0, 4'h0, 0);
    check("lat1.en", 32'(en1), 32'hF);
    tick();
    outs("mem_b", 0, 4'h0, 4'h0, 0);
    tick();
    outs("mem_c", 1, 4'hF, 4'h0, 0);
    tick();
    outs("mem_norearm", 1, 4'hF, 4'h0, 0);
    tick(); cnts("mem", 4, 1, 2);

    // 5: halt_req held through a freeze, then taken on the advancing cycle
    halt_req = 1;
    outs("hf_a", 0, 4'h0, 4'h0, 0);
    tick();
    outs("hf_b", 0, 4'h0, 4'h0, 0);
    tick();
    outs("hf_c", 1, 4'hF, 4'h0, 0);
    tick(); idle();
    for (int i = 0; i < 5; i++) begin
      ex_is_branch = 1; ex_mispredict = 1;
      outs("halt", 0, 4'h0, 4'h0, 1);
      tick();
    end
    idle();
    cnts("halt", 6, 1, 2);
    resume = 1;
    outs("halt_res", 0, 4'h0, 4'h0, 1);
    tick(); resume = 0;
    outs("run_again", 1, 4'hF, 4'h0, 0);
    tick(); cnts("run_again", 6, 1, 2);

    // 6: reset while in MEM_WAIT with stall_cnt=7
    mem_req = 1;
    tick(); mem_req = 0;
    check("pre_rst.stall", 32'(stall_cnt), 32'd7);
    rst_n = 0;
    outs("async_rst", 1, 4'hF, 4'h0, 0);
    cnts("async_rst", 0, 0, 0);
    tick(); rst_n = 1;
    outs("post_rst", 1, 4'hF, 4'h0, 0);

    // stall counter wrap at 2^CNT_W
    load_use_rs(5'd9);
    for (int i = 0; i < 15; i++) tick();
    check("wrap.max", 32'(stall_cnt), 32'd15);
    tick(); idle();
    check("wrap.zero", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
